wb_stage_p: RTL
===============

Name: wb_stage_p

Overview:
- Parametrised two-stage writeback unit for the RISC-V integer pipeline, sitting after the memory stage and driving the register-file write port.
- Decodes the retiring instruction and performs load byte/half/word(/double) extraction from the raw memory word using the low address bits.
- Detects misaligned and unsupported loads.
- Provides a last-write forwarding register, a retired-instruction counter, and stall/flush handling.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CNT_W, 32, width of instret counter.
- OFF_W, 2 when XLEN=32 and 3 when XLEN=64 (derived, localparam), byte-offset width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold stage 1; insert bubble into stage 2
- flush  in  1  kill stage-1 contents and any incoming instruction
- in_valid  in  1  incoming instruction is valid
- in_inst  in  32  instruction word
- in_result  in  XLEN  ALU/LUI/AUIPC result
- in_pc_plus_4  in  XLEN  link value
- in_mem_rdata  in  XLEN  raw aligned memory word
- in_addr_lo  in  OFF_W  low bits of load address
- rf_we  out  1  register-file write enable
- rf_rd  out  5  destination register
- rf_wdata  out  XLEN  write data
- fwd_valid  out  1  fwd_rd/fwd_data hold a committed write
- fwd_rd  out  5  last committed rd
- fwd_data  out  XLEN  last committed data
- misalign  out  1  one-cycle pulse: misaligned load retired
- illegal  out  1  one-cycle pulse: unsupported load funct3 retired
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, immediate): stage valids=0, rf_we=0, rf_rd=0, rf_wdata=0, fwd_valid=0, fwd_rd=0, fwd_data=0, misalign=0, illegal=0, instret=0.
- Stage 1 (posedge):
  - flush=1: s1_valid<=0. flush has priority over stall.
  - Else stall=1: hold all stage-1 registers.
  - Else capture s1_valid<=in_valid, the decoded fields, and the data inputs.
- Decode:
  - OP_IMM/OP/LUI/AUIPC → write, select result.
  - JAL/JALR → write, select pc_plus_4.
  - LOAD → write, select extracted memory data.
  - All other opcodes → no write, but count as retired.
  - rd==0 always suppresses the write (x0 never written; still retires).
- Load extraction (stage 1→2 path), byte lane selected by in_addr_lo:
  - LB/LBU: sign/zero-extend byte at offset.
  - LH/LHU: halfword at offset.
  - LW: word at offset; XLEN=64 sign-extends. LWU (XLEN=64 only) zero-extends.
  - LD: XLEN=64 only, full word.
- Misalign rule: halfword with addr_lo[0]≠0; word with addr_lo[1:0]≠0; double with addr_lo≠0. Result: no write, not counted, misalign=1 for one cycle.
- Illegal rule: funct3 011/110 when XLEN=32, or funct3 111. Result: no write, not counted, illegal=1 for one cycle.
- Stage 2 (posedge):
  - If stall=1, or flush=1 and stall=0, stage 2 loads a bubble: rf_we<=0, pulses<=0.
  - Else it takes stage 1: rf_we<=s1_valid&write&ok, rf_rd, rf_wdata.
  - Latency: accepted instruction writes 2 cycles after capture edge (rf_we high during cycle after second edge), absent stalls.
- instret: +1 on each edge where stage 2 retires a valid, non-faulting instruction; wraps modulo 2^CNT_W.
- Forwarding register: updated with (rf_rd, rf_wdata) on the same edge rf_we is set; fwd_valid set then; holds across bubbles/stalls.
- rf_wdata and rf_rd hold their previous values when rf_we=0.
- Reset mid-operation discards both stages immediately.

Test Plan:
- ADDI x5 (in_result=0x0000_1234), no stall → 2 edges later rf_we=1, rf_rd=5, rf_wdata=0x1234; instret=1; fwd_rd=5, fwd_data=0x1234.
- LB x3, mem_rdata=0x80FF_7F01, addr_lo=3 → rf_wdata=0xFFFF_FF80. LBU same → 0x0000_0080. LH addr_lo=2 → 0xFFFF_80FF.
- LW x4, addr_lo=1 → rf_we stays 0, misalign pulses one cycle, instret unchanged. funct3=011 with XLEN=32 → illegal pulses.
- JAL x0 and SW → rf_we=0, instret +1 each; JAL x1 with pc_plus_4=0x104 → rf_wdata=0x104.
- ADD x7 accepted, then stall high 3 cycles → rf_we=0 those cycles; stage 1 held; write of x7 appears on first edge after stall drops; flush with stall both high → instruction dropped, never written.
- CNT_W=4, retire 17 instructions → instret=1. Assert reset mid-pipeline with two valid ops → all outputs 0 immediately, no writes after release.

Source files
------------

// File: rtl/wb_stage_p.sv
// Two-stage RISC-V writeback: stage 1 latches the retiring instruction, and the
// stage 1->2 path extracts load data and checks alignment before the register file is written.
module wb_stage_p #(
    parameter  int XLEN  = 32,
    parameter  int CNT_W = 32,
    localparam int OFF_W = (XLEN == 64) ? 3 : 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_result,
    input  logic [XLEN-1:0]  in_pc_plus_4,
    input  logic [XLEN-1:0]  in_mem_rdata,
    input  logic [OFF_W-1:0] in_addr_lo,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             misalign,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {SEL_RES, SEL_PC4, SEL_MEM} sel_e;

    logic             in_write, in_load;
    sel_e             in_sel;
    logic             unused_inst_bits;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_write_q, s1_write_d;
    logic             s1_load_q, s1_load_d;
    sel_e             s1_sel_q, s1_sel_d;
    logic [4:0]       s1_rd_q, s1_rd_d;
    logic [2:0]       s1_f3_q, s1_f3_d;
    logic [XLEN-1:0]  s1_result_q, s1_result_d;
    logic [XLEN-1:0]  s1_pc4_q, s1_pc4_d;
    logic [XLEN-1:0]  s1_mem_q, s1_mem_d;
    logic [OFF_W-1:0] s1_addr_q, s1_addr_d;

    logic [XLEN-1:0]  shifted, load_data, sel_data;
    logic             ld_ill, ld_mis, fault;

    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [4:0]       fwd_rd_q, fwd_rd_d;
    logic [XLEN-1:0]  fwd_data_q, fwd_data_d;
    logic             misalign_q, misalign_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    assign unused_inst_bits = ^in_inst[31:15];

    always_comb begin
        in_write = 1'b0;
        in_load  = 1'b0;
        in_sel   = SEL_RES;
        case (in_inst[6:0])
            OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC: in_write = 1'b1;
            OPC_JAL, OPC_JALR: begin
                in_write = 1'b1;
                in_sel   = SEL_PC4;
            end
            OPC_LOAD: begin
                in_write = 1'b1;
                in_load  = 1'b1;
                in_sel   = SEL_MEM;
            end
            default: ;
        endcase
    end

    // flush outranks stall; a stalled stage 1 ignores whatever is arriving
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_write_d  = s1_write_q;
        s1_load_d   = s1_load_q;
        s1_sel_d    = s1_sel_q;
        s1_rd_d     = s1_rd_q;
        s1_f3_d     = s1_f3_q;
        s1_result_d = s1_result_q;
        s1_pc4_d    = s1_pc4_q;
        s1_mem_d    = s1_mem_q;
        s1_addr_d   = s1_addr_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (!stall) begin
            s1_valid_d  = in_valid;
            s1_write_d  = in_write && (in_inst[11:7] != 5'd0);
            s1_load_d   = in_load;
            s1_sel_d    = in_sel;
            s1_rd_d     = in_inst[11:7];
            s1_f3_d     = in_inst[14:12];
            s1_result_d = in_result;
            s1_pc4_d    = in_pc_plus_4;
            s1_mem_d    = in_mem_rdata;
            s1_addr_d   = in_addr_lo;
        end
    end

    always_comb begin
        shifted = s1_mem_q >> {s1_addr_q, 3'b000};
        case (s1_f3_q)
            3'b000:  load_data = XLEN'($signed(shifted[7:0]));
            3'b001:  load_data = XLEN'($signed(shifted[15:0]));
            3'b010:  load_data = XLEN'($signed(shifted[31:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b101:  load_data = XLEN'(shifted[15:0]);
            3'b110:  load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase

        ld_ill = s1_load_q && ((s1_f3_q == 3'b111) ||
                 ((XLEN == 32) && ((s1_f3_q == 3'b011) || (s1_f3_q == 3'b110))));
        ld_mis = 1'b0;
        if (s1_load_q && !ld_ill) begin
            case (s1_f3_q[1:0])
                2'b01:   ld_mis = s1_addr_q[0];
                2'b10:   ld_mis = (s1_addr_q[1:0] != 2'b00);
                2'b11:   ld_mis = (s1_addr_q != '0);
                default: ld_mis = 1'b0;
            endcase
        end
        fault = ld_ill || ld_mis;

        case (s1_sel_q)
            SEL_PC4: sel_data = s1_pc4_q;
            SEL_MEM: sel_data = load_data;
            default: sel_data = s1_result_q;
        endcase
    end

    always_comb begin
        rf_we_d     = 1'b0;
        misalign_d  = 1'b0;
        illegal_d   = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_wdata_d  = rf_wdata_q;
        fwd_valid_d = fwd_valid_q;
        fwd_rd_d    = fwd_rd_q;
        fwd_data_d  = fwd_data_q;
        instret_d   = instret_q;
        if (!stall && !flush) begin
            rf_we_d    = s1_valid_q && s1_write_q && !fault;
            misalign_d = s1_valid_q && ld_mis;
            illegal_d  = s1_valid_q && ld_ill;
            if (rf_we_d) begin
                rf_rd_d     = s1_rd_q;
                rf_wdata_d  = sel_data;
                fwd_valid_d = 1'b1;
                fwd_rd_d    = s1_rd_q;
                fwd_data_d  = sel_data;
            end
            if (s1_valid_q && !fault) instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_write_q  <= 1'b0;
            s1_load_q   <= 1'b0;
            s1_sel_q    <= SEL_RES;
            s1_rd_q     <= '0;
            s1_f3_q     <= '0;
            s1_result_q <= '0;
            s1_pc4_q    <= '0;
            s1_mem_q    <= '0;
            s1_addr_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_wdata_q  <= '0;
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= '0;
            fwd_data_q  <= '0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
            instret_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_write_q  <= s1_write_d;
            s1_load_q   <= s1_load_d;
            s1_sel_q    <= s1_sel_d;
            s1_rd_q     <= s1_rd_d;
            s1_f3_q     <= s1_f3_d;
            s1_result_q <= s1_result_d;
            s1_pc4_q    <= s1_pc4_d;
            s1_mem_q    <= s1_mem_d;
            s1_addr_q   <= s1_addr_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_rd_q    <= fwd_rd_d;
            fwd_data_q  <= fwd_data_d;
            misalign_q  <= misalign_d;
            illegal_q   <= illegal_d;
            instret_q   <= instret_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_wdata  = rf_wdata_q;
    assign fwd_valid = fwd_valid_q;
    assign fwd_rd    = fwd_rd_q;
    assign fwd_data  = fwd_data_q;
    assign misalign  = misalign_q;
    assign illegal   = illegal_q;
    assign instret   = instret_q;

endmodule
